// File: rtl/particle_step_sequencer_if.sv
// Operand/result bus between the step sequencer and the
// combinational Verlet integration stage.
interface particle_step_sequencer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] integ_x;
  logic [WIDTH-1:0] integ_y;
  logic [WIDTH-1:0] integ_px;
  logic [WIDTH-1:0] integ_py;
  logic [WIDTH-1:0] integ_fixed_x;
  logic [WIDTH-1:0] integ_fixed_y;

  modport master (
    output integ_x, integ_y,
    output integ_px, integ_py,
    input  integ_fixed_x, integ_fixed_y
  );

  modport slave (
    input  integ_x, integ_y,
    input  integ_px, integ_py,
    output integ_fixed_x, integ_fixed_y
  );
endinterface

// File: rtl/particle_step_sequencer.sv
// Particle state store and per-frame walk feeding the Verlet
// integrator; applies pinning and boundary clamping on write-back.
module particle_step_sequencer #(
  parameter int WIDTH = 32,
  parameter int NUM_PARTICLES = 16,
  parameter int IDX_W = 4,
  parameter logic [WIDTH-1:0] X_MAX = 32'h01400000,
  parameter logic [WIDTH-1:0] Y_MAX = 32'h00F00000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             load_valid,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [WIDTH-1:0] load_x,
  input  logic [WIDTH-1:0] load_y,
  input  logic             load_pin,
  particle_step_sequencer_if.master integ,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_x,
  output logic [WIDTH-1:0] rd_y
);

  typedef enum logic [1:0] {
    IDLE, FETCH, WRITE, DONE
  } state_t;

  localparam logic signed [WIDTH-1:0] XMAX_S = $signed(X_MAX);
  localparam logic signed [WIDTH-1:0] YMAX_S = $signed(Y_MAX);

  state_t state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic last;

  logic [WIDTH-1:0] cur_x  [NUM_PARTICLES];
  logic [WIDTH-1:0] cur_y  [NUM_PARTICLES];
  logic [WIDTH-1:0] prev_x [NUM_PARTICLES];
  logic [WIDTH-1:0] prev_y [NUM_PARTICLES];
  logic [NUM_PARTICLES-1:0] pin;

  logic [WIDTH-1:0] op_x, op_y, op_px, op_py;
  logic signed [WIDTH-1:0] fx, fy;
  logic [WIDTH-1:0] cx, cy;
  logic clx, cly;

  assign integ.integ_x  = op_x;
  assign integ.integ_y  = op_y;
  assign integ.integ_px = op_px;
  assign integ.integ_py = op_py;

  assign last = (idx == IDX_W'(NUM_PARTICLES - 1));
  assign fx = $signed(integ.integ_fixed_x);
  assign fy = $signed(integ.integ_fixed_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy = (state != IDLE);
    done = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: state_nxt = WRITE;
      WRITE: state_nxt = last ? DONE : FETCH;
      DONE: begin
        done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A clamped axis also gets prev = clamped value so it stops dead.
  always_comb begin
    cx = integ.integ_fixed_x;
    cy = integ.integ_fixed_y;
    clx = 1'b0;
    cly = 1'b0;
    if (fx < 0) begin
      cx = '0;
      clx = 1'b1;
    end else if (fx > XMAX_S) begin
      cx = X_MAX;
      clx = 1'b1;
    end
    if (fy < 0) begin
      cy = '0;
      cly = 1'b1;
    end else if (fy > YMAX_S) begin
      cy = Y_MAX;
      cly = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      op_x  <= '0;
      op_y  <= '0;
      op_px <= '0;
      op_py <= '0;
      rd_x  <= '0;
      rd_y  <= '0;
      pin   <= '0;
      for (int i = 0; i < NUM_PARTICLES; i++) begin
        cur_x[i]  <= '0;
        cur_y[i]  <= '0;
        prev_x[i] <= '0;
        prev_y[i] <= '0;
      end
    end else begin
      rd_x <= cur_x[rd_idx];
      rd_y <= cur_y[rd_idx];
      unique case (state)
        IDLE: begin
          if (load_valid) begin
            cur_x[load_idx]  <= load_x;
            cur_y[load_idx]  <= load_y;
            prev_x[load_idx] <= load_x;
            prev_y[load_idx] <= load_y;
            pin[load_idx]    <= load_pin;
          end
          if (start) idx <= '0;
        end
        FETCH: begin
          op_x  <= cur_x[idx];
          op_y  <= cur_y[idx];
          op_px <= prev_x[idx];
          op_py <= prev_y[idx];
        end
        WRITE: begin
          if (!pin[idx]) begin
            cur_x[idx]  <= cx;
            cur_y[idx]  <= cy;
            prev_x[idx] <= clx ? cx : op_x;
            prev_y[idx] <= cly ? cy : op_y;
          end
          if (!last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_particle_step_sequencer.sv
// Directed and randomized steps of particle_step_sequencer against
// a per-particle Verlet/clamp reference model.
module tb_particle_step_sequencer;
  localparam int W = 32;
  localparam int N = 16;
  localparam int IW = 4;
  localparam logic [W-1:0] XM = 32'h01400000;
  localparam logic [W-1:0] YM = 32'h00F00000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic load_valid = 1'b0;
  logic load_pin = 1'b0;
  logic [IW-1:0] load_idx = '0;
  logic [IW-1:0] rd_idx = '0;
  logic [W-1:0] load_x = '0;
  logic [W-1:0] load_y = '0;
  logic [W-1:0] rd_x, rd_y;
  logic busy, done;
  logic [W-1:0] dx = '0;
  logic [W-1:0] dy = '0;

  logic [W-1:0] m_cx [N];
  logic [W-1:0] m_cy [N];
  logic [W-1:0] m_px [N];
  logic [W-1:0] m_py [N];
  bit m_pin [N];

  int vecs = 0;
  int errs = 0;

  particle_step_sequencer_if #(.WIDTH(W)) intf ();

  assign intf.integ_fixed_x = 2 * intf.integ_x - intf.integ_px + dx;
  assign intf.integ_fixed_y = 2 * intf.integ_y - intf.integ_py + dy;

  always #5 clk = ~clk;

  particle_step_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .busy(busy), .done(done),
    .load_valid(load_valid), .load_idx(load_idx),
    .load_x(load_x), .load_y(load_y), .load_pin(load_pin),
    .integ(intf),
    .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y)
  );

  task automatic check(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit clampv(input logic [W-1:0] v,
                                input logic [W-1:0] mx,
                                output logic [W-1:0] r);
    if ($signed(v) < 0) begin
      r = '0;
      return 1'b1;
    end
    if ($signed(v) > $signed(mx)) begin
      r = mx;
      return 1'b1;
    end
    r = v;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cx[i] = '0; m_cy[i] = '0;
      m_px[i] = '0; m_py[i] = '0;
      m_pin[i] = 1'b0;
    end
  endtask

  task automatic model_load(input int k, input logic [W-1:0] x,
                            input logic [W-1:0] y, input bit p);
    m_cx[k] = x; m_px[k] = x;
    m_cy[k] = y; m_py[k] = y;
    m_pin[k] = p;
  endtask

  task automatic model_particle(input int k);
    logic [W-1:0] nx, ny, rx, ry;
    bit cx, cy;
    if (m_pin[k]) return;
    nx = 2 * m_cx[k] - m_px[k] + dx;
    ny = 2 * m_cy[k] - m_py[k] + dy;
    cx = clampv(nx, XM, rx);
    cy = clampv(ny, YM, ry);
    m_px[k] = cx ? rx : m_cx[k];
    m_py[k] = cy ? ry : m_cy[k];
    m_cx[k] = rx;
    m_cy[k] = ry;
  endtask

  task automatic do_load(input int k, input logic [W-1:0] x,
                         input logic [W-1:0] y, input bit p);
    @(negedge clk);
    load_valid = 1'b1;
    load_idx = IW'(k);
    load_x = x; load_y = y; load_pin = p;
    @(negedge clk);
    load_valid = 1'b0;
    model_load(k, x, y, p);
  endtask

  // Cycle c after the accepting edge is checked at its falling edge.
  task automatic run_step(input bit inj, input bit ld, input int k,
                          input logic [W-1:0] x,
                          input logic [W-1:0] y);
    int p;
    @(negedge clk);
    start = 1'b1;
    if (ld) begin
      load_valid = 1'b1;
      load_idx = IW'(k);
      load_x = x; load_y = y; load_pin = 1'b0;
      model_load(k, x, y, 1'b0);
    end
    for (int c = 1; c <= 2 * N + 2; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        load_valid = 1'b0;
      end
      if (inj && c == 10) begin
        start = 1'b1;
        load_valid = 1'b1;
        load_idx = IW'($urandom);
        load_x = $urandom; load_y = $urandom;
        load_pin = 1'($urandom);
      end
      if (inj && c == 11) begin
        start = 1'b0;
        load_valid = 1'b0;
      end
      check("busy", W'(busy), W'(c <= 2 * N + 1));
      check("done", W'(done), W'(c == 2 * N + 1));
      if (c % 2 == 0 && c <= 2 * N) begin
        p = (c - 2) / 2;
        check("integ_x", intf.integ_x, m_cx[p]);
        check("integ_y", intf.integ_y, m_cy[p]);
        check("integ_px", intf.integ_px, m_px[p]);
        check("integ_py", intf.integ_py, m_py[p]);
        model_particle(p);
      end
    end
  endtask

  task automatic read_one(input int k, output logic [W-1:0] x,
                          output logic [W-1:0] y);
    @(negedge clk);
    rd_idx = IW'(k);
    @(negedge clk);
    x = rd_x;
    y = rd_y;
  endtask

  task automatic check_all();
    logic [W-1:0] x, y;
    for (int i = 0; i < N; i++) begin
      read_one(i, x, y);
      check("rd_x", x, m_cx[i]);
      check("rd_y", y, m_cy[i]);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, W'(busy), '0);
    check({tag, "_done"}, W'(done), '0);
    check({tag, "_ix"}, intf.integ_x, '0);
    check({tag, "_iy"}, intf.integ_y, '0);
    check({tag, "_ipx"}, intf.integ_px, '0);
    check({tag, "_ipy"}, intf.integ_py, '0);
    check({tag, "_rdx"}, rd_x, '0);
    check({tag, "_rdy"}, rd_y, '0);
  endtask

  initial begin
    logic [W-1:0] x, y;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero_outputs("por");
    rst_n = 1'b1;

    // reset mid-step
    do_load(5, 32'h00200000, 32'h00300000, 1'b0);
    dy = 32'h333;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    read_one(5, x, y);
    check("rst_rd5_x", x, '0);
    check("rst_rd5_y", y, '0);
    check("rst_busy", W'(busy), '0);

    // free fall
    dx = '0;
    dy = 32'h333;
    do_load(0, 32'h00100000, 32'h00100000, 1'b0);
    run_step(1'b0, 1'b0, 0, '0, '0);
    read_one(0, x, y);
    check("ff_x", x, 32'h00100000);
    check("ff_y", y, 32'h00100333);
    check_all();
    run_step(1'b0, 1'b0, 0, '0, '0);

    // pin
    do_load(3, 32'h10, 32'h20, 1'b1);
    repeat (3) run_step(1'b0, 1'b0, 0, '0, '0);
    read_one(3, x, y);
    check("pin_x", x, 32'h10);
    check("pin_y", y, 32'h20);

    // clamp both axes
    dx = '1;
    dy = 32'h1;
    do_load(1, '0, YM, 1'b0);
    run_step(1'b0, 1'b0, 0, '0, '0);
    read_one(1, x, y);
    check("clamp_x", x, '0);
    check("clamp_y", y, YM);
    dx = '0;
    dy = '0;
    run_step(1'b0, 1'b0, 0, '0, '0);
    read_one(1, x, y);
    check("still_x", x, '0);
    check("still_y", y, YM);
    check_all();

    // ignored mid-step inputs, then load together with start
    dy = 32'h333;
    run_step(1'b1, 1'b0, 0, '0, '0);
    check_all();
    run_step(1'b0, 1'b1, 7, 32'h00012345, 32'h00023456);
    check_all();

    // randomized
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          x = $urandom;
          y = $urandom;
        end else begin
          x = $urandom_range(0, 32'h01400000);
          y = $urandom_range(0, 32'h00F00000);
        end
        do_load(int'($urandom_range(0, N - 1)), x, y,
                bit'($urandom_range(0, 4) == 0));
      end
      dx = $urandom_range(0, 32'h3FFFF) - 32'h20000;
      dy = $urandom_range(0, 32'h3FFFF) - 32'h20000;
      run_step(bit'($urandom_range(0, 1)), 1'b0, 0, '0, '0);
      check_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/particle_step_sequencer.md
# particle_step_sequencer

Owns the particle state store (current and previous X/Y per particle plus a pin flag) and steps the cloth simulation one frame per `start` pulse. It walks the particles in index order, presents each particle's operands to the external combinational Verlet integration stage, and captures that stage's `fixed_x`/`fixed_y` result. It applies pinning and boundary clamping to the result and writes it back. It sits directly upstream of the integrator and also consumes the integrator's result. The renderer reads positions back through a registered read port.

## Interface
- `WIDTH`, 32, position word width, two's complement fixed point
- `NUM_PARTICLES`, 16, particle count (power of two)
- `IDX_W`, 4, index width, log2(NUM_PARTICLES)
- `X_MAX`, 32'h01400000, upper X bound (signed compare), lower bound 0
- `Y_MAX`, 32'h00F00000, upper Y bound (signed compare), lower bound 0
- `clk` in 1 — single clock, all state on rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `start` in 1 — begin one simulation step; sampled only in IDLE
- `busy` out 1 — high in every state except IDLE
- `done` out 1 — one-cycle pulse when a step completes
- `load_valid` in 1 — write one particle's initial state; sampled only in IDLE
- `load_idx` in IDX_W — particle to load
- `load_x`, `load_y` in WIDTH — initial position
- `load_pin` in 1 — 1 = particle is pinned (never moves)
- `integ_x`, `integ_y`, `integ_px`, `integ_py` out WIDTH — operands to integrator: current and previous position
- `integ_fixed_x`, `integ_fixed_y` in WIDTH — integrator result; combinational from the `integ_*` operands
- `rd_idx` in IDX_W — renderer read index
- `rd_x`, `rd_y` out WIDTH — registered current position of `rd_idx`

## Operation
- Store: arrays `cur_x`, `cur_y`, `prev_x`, `prev_y` and `pin`, each NUM_PARTICLES entries.
- Load in IDLE:
  - `cur` and `prev` are both set to `load_x`/`load_y`, giving zero velocity.
  - `pin` is set to `load_pin`.
  - `load_valid` outside IDLE is ignored.
- FSM states: IDLE, FETCH, WRITE, DONE.
  - IDLE→FETCH when `start`=1; `idx` is set to 0.
  - FETCH→WRITE unconditionally. In FETCH, the `integ_*` operand registers are loaded from the arrays at `idx`.
  - WRITE→FETCH with `idx`+1 if `idx` != NUM_PARTICLES-1; WRITE→DONE otherwise.
  - DONE→IDLE unconditionally. `done`=1 only in DONE.
- WRITE, per particle `idx`, using `integ_fixed_x`/`integ_fixed_y` sampled this cycle:
  - Pinned: no array write.
  - Otherwise `prev` is set to the operand `integ_x`/`integ_y` (old current position) and `cur` is set to the clamped result.
  - Clamp, per axis, as a signed compare: result < 0 → 0; result > MAX → MAX; else unchanged.
  - If an axis clamps, that axis's `prev` is also set to the clamped value, killing velocity on that axis.
- `start` while busy is ignored; there is no queuing.
- `load_valid` and `start` in the same IDLE cycle: the load is applied and the step starts. The first FETCH sees the loaded values.
- `integ_*` registers hold their last values outside FETCH/WRITE.
- `rd_x`/`rd_y` are updated every cycle from `cur_x[rd_idx]`/`cur_y[rd_idx]`.
  - Readable at any time, including mid-step.
  - A read of a particle written in the same WRITE cycle returns the old value.

## Timing
- Reset (async assert, sync-released use):
  - State IDLE, `idx`=0.
  - All array entries and pin flags 0.
  - `busy`=0, `done`=0, `integ_*`=0, `rd_x`=`rd_y`=0.
- A reset mid-step aborts immediately. There is no partial-step recovery.
- `start` high at edge t:
  - FETCH of particle k in cycle t+1+2k; WRITE in cycle t+2+2k.
  - `done`=1 in cycle t+2N+1; IDLE and `busy`=0 at t+2N+2.
  - A new `start` is accepted at the edge ending cycle t+2N+2.
- Step latency is 2·NUM_PARTICLES+1 cycles from accept to `done`; it is 33 for the defaults.
- A load is visible on `rd_x`/`rd_y` two edges after the load edge: one for the array write, one for the read register.

## Test plan
- Reset and load:
  - Stimulus: assert `rst_n`=0 mid-step, release.
  - Response: all outputs 0, `busy`=0; `rd_idx`=5 gives `rd_x`=`rd_y`=0.
- Free fall, one particle step:
  - Setup: load idx 0 at (0x00100000, 0x00100000), unpinned; model the integrator as 2x−px and 2y−py+0x333.
  - Response: after `done`, `cur_y`=0x00100333, `prev_y`=0x00100000, `cur_x` unchanged.
- Timing:
  - `start` at edge t.
  - Response: `done` exactly in cycle t+33, a single pulse; `busy` high for cycles t+1..t+33.
- Pin:
  - Load idx 3 pinned at (0x10, 0x20) and run 3 steps.
  - Response: `rd_x`=0x10, `rd_y`=0x20, and prev is unchanged.
- Clamp:
  - Integrator returns `integ_fixed_y`=Y_MAX+1, and in another case `integ_fixed_x`=−1.
  - Response: `cur_y`=`prev_y`=Y_MAX; `cur_x`=`prev_x`=0.
- Ignored inputs:
  - `start` and `load_valid` pulsed mid-step.
  - Response: no restart, no store change, `done` timing unchanged.
  - `load_valid` and `start` in the same IDLE cycle: the step uses the loaded value.
